// File: rtl/qspi_flash_responder_pkg.sv
// Shared types and constants for the QSPI flash responder.
// QSPI_RESP_SPI_CMD_EN selects a single-lane command phase.
package qspi_flash_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } qspi_resp_state_t;

    localparam logic [7:0] QSPI_CMD_QUAD_READ = 8'hEB;

    localparam int CMD_BITS   = 8;
    localparam int ADDR_BITS  = 24;
    localparam int ADDR_LANES = 4;
    localparam int ADDR_EDGES = ADDR_BITS / ADDR_LANES;

`ifdef QSPI_RESP_SPI_CMD_EN
    localparam int CMD_LANES = 1;
`else
    localparam int CMD_LANES = 4;
`endif

    localparam int CMD_EDGES = CMD_BITS / CMD_LANES;

endpackage

// File: rtl/qspi_flash_responder_shift_in.sv
// Serial-in shift register of N words of W bits with a done-count.
// Cleared whenever chip select is high.
module qspi_shift_in #(
    parameter int W = 4,
    parameter int N = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clr_i,
    input  logic           en_i,
    input  logic [W-1:0]   din_i,
    output logic [W*N-1:0] data_o,
    output logic           last_o
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [W*N-1:0] data_q;
    logic [CW-1:0]  cnt_q;

    // Word including the lane value being sampled this edge.
    assign data_o = {data_q[W*(N-1)-1:0], din_i};
    assign last_o = (cnt_q == CW'(N - 1));

    // Shift one word per enabled edge; count wraps after the last one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (en_i) begin
            data_q <= data_o;
            cnt_q  <= last_o ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/qspi_flash_responder.sv
// QSPI flash target answering 0xEB quad I/O reads from a memory backend.
// Define QSPI_RESP_SPI_CMD_EN for a single-lane (io_in[0]) command phase.
module qspi_flash_responder
    import qspi_flash_responder_pkg::*;
#(
    parameter int ADDR_W       = 24,
    parameter int DUMMY_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csb,
    input  logic [3:0]        io_in,
    output logic [3:0]        io_out,
    output logic              io_oe,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    localparam int DCW = $clog2(DUMMY_CYCLES);

    if (DUMMY_CYCLES < 2) begin : g_dummy_chk
        $error("DUMMY_CYCLES must be at least 2");
    end
    if (ADDR_W < 1 || ADDR_W > ADDR_BITS) begin : g_addr_chk
        $error("ADDR_W must be within 1..24");
    end

    qspi_resp_state_t  state_q;
    logic              armed_q;
    logic              half_q;
    logic [DCW-1:0]    dcnt_q;
    logic [3:0]        io_out_q;
    logic              io_oe_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              cmd_err_q;

    logic                cmd_en;
    logic                cmd_last;
    logic [CMD_BITS-1:0] cmd_word;
    logic                addr_en;
    logic                addr_last;
    logic [ADDR_BITS-1:0] addr_word;
    logic [ADDR_W-1:0]   addr_inc_d;

    assign cmd_en  = !csb && ((state_q == ST_IDLE && armed_q)
                              || state_q == ST_CMD);
    assign addr_en = !csb && (state_q == ST_ADDR);
    assign addr_inc_d = mem_addr_q + ADDR_W'(1);

    qspi_shift_in #(
        .W (CMD_LANES),
        .N (CMD_EDGES)
    ) u_cmd (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (csb),
        .en_i   (cmd_en),
        .din_i  (io_in[CMD_LANES-1:0]),
        .data_o (cmd_word),
        .last_o (cmd_last)
    );

    qspi_shift_in #(
        .W (ADDR_LANES),
        .N (ADDR_EDGES)
    ) u_addr (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (csb),
        .en_i   (addr_en),
        .din_i  (io_in),
        .data_o (addr_word),
        .last_o (addr_last)
    );

    // Transaction FSM with registered pin and backend outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            armed_q    <= 1'b0;
            half_q     <= 1'b0;
            dcnt_q     <= '0;
            io_out_q   <= 4'h0;
            io_oe_q    <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            cmd_err_q  <= 1'b0;
        end else begin
            mem_req_q <= 1'b0;
            cmd_err_q <= 1'b0;
            if (csb) begin
                state_q  <= ST_IDLE;
                armed_q  <= 1'b1;
                half_q   <= 1'b0;
                dcnt_q   <= '0;
                io_out_q <= 4'h0;
                io_oe_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (armed_q) state_q <= ST_CMD;
                    end
                    ST_CMD: begin
                        if (cmd_last) begin
                            if (cmd_word == QSPI_CMD_QUAD_READ) begin
                                state_q <= ST_ADDR;
                            end else begin
                                state_q   <= ST_IGNORE;
                                cmd_err_q <= 1'b1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (addr_last) begin
                            state_q    <= ST_DUMMY;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= addr_word[ADDR_W-1:0];
                        end
                    end
                    ST_DUMMY: begin
                        if (dcnt_q == DCW'(DUMMY_CYCLES - 1)) begin
                            state_q    <= ST_DATA;
                            dcnt_q     <= '0;
                            io_oe_q    <= 1'b1;
                            io_out_q   <= mem_rdata[7:4];
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= addr_inc_d;
                            half_q     <= 1'b1;
                        end else begin
                            dcnt_q <= dcnt_q + DCW'(1);
                        end
                    end
                    ST_DATA: begin
                        if (half_q) begin
                            io_out_q <= mem_rdata[3:0];
                            half_q   <= 1'b0;
                        end else begin
                            io_out_q   <= mem_rdata[7:4];
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= addr_inc_d;
                            half_q     <= 1'b1;
                        end
                    end
                    ST_IGNORE: begin
                        io_oe_q <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign io_out   = io_out_q;
    assign io_oe    = io_oe_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign cmd_err  = cmd_err_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Scoreboard bench for qspi_flash_responder (ADDR_W=8, 4 dummy cycles).
// Honours QSPI_RESP_SPI_CMD_EN for the command phase layout.
module tb_qspi_flash_responder;

    localparam int AW = 8;
    localparam int DC = 4;
`ifdef QSPI_RESP_SPI_CMD_EN
    localparam int CE = 8;
`else
    localparam int CE = 2;
`endif

    typedef struct {
        int e;
        int v;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          csb;
    logic [3:0]    io_in;
    logic [3:0]    io_out;
    logic          io_oe;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata = 8'h00;
    logic          busy;
    logic          cmd_err;

    logic [7:0] mem [256];
    ev_t q_req[$];
    ev_t q_nib[$];
    ev_t q_err[$];
    int  kcnt = -1;
    bit  tarmed = 1'b0;
    int  checks = 0;
    int  errors = 0;

    qspi_flash_responder #(
        .ADDR_W       (AW),
        .DUMMY_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .csb       (csb),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oe     (io_oe),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    // Backend: one-cycle read latency, data held until next request.
    always @(posedge clk) begin
        if (mem_req) mem_rdata <= mem[mem_addr];
    end

    // Edge index within the current transaction (-1 when not in one).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            kcnt   = -1;
            tarmed = 1'b0;
        end else if (csb) begin
            kcnt   = -1;
            tarmed = 1'b1;
        end else if (tarmed) begin
            kcnt = kcnt + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented output event against the queues.
    always @(negedge clk) begin
        ev_t ev;
        if (!rst) begin
            chk("busy", int'(busy), int'(kcnt >= 0));
            if (mem_req === 1'b1) begin
                checks++;
                if (q_req.size() == 0) begin
                    errors++;
                    $display("FAIL req_unexpected edge %0d addr %0h",
                             kcnt, mem_addr);
                end else begin
                    ev = q_req.pop_front();
                    if (ev.e != kcnt || ev.v != int'(mem_addr)) begin
                        errors++;
                        $display("FAIL req got edge %0d addr %0h expected edge %0d addr %0h",
                                 kcnt, mem_addr, ev.e, ev.v);
                    end
                end
            end
            if (io_oe === 1'b1) begin
                checks++;
                if (q_nib.size() == 0) begin
                    errors++;
                    $display("FAIL nib_unexpected edge %0d nib %0h",
                             kcnt, io_out);
                end else begin
                    ev = q_nib.pop_front();
                    if (ev.e != kcnt || ev.v != int'(io_out)) begin
                        errors++;
                        $display("FAIL nib got edge %0d nib %0h expected edge %0d nib %0h",
                                 kcnt, io_out, ev.e, ev.v);
                    end
                end
            end
            if (cmd_err === 1'b1) begin
                checks++;
                if (q_err.size() == 0) begin
                    errors++;
                    $display("FAIL err_unexpected edge %0d", kcnt);
                end else begin
                    ev = q_err.pop_front();
                    if (ev.e != kcnt) begin
                        errors++;
                        $display("FAIL err got edge %0d expected edge %0d",
                                 kcnt, ev.e);
                    end
                end
            end
        end
    end

    // Reference: events of a transaction whose csb stays low for edges 0..t-1.
    task automatic push_model(input logic [7:0] cmd, input int addr,
                              input int t);
        int a;
        int s;
        int i;
        int b;
        if (cmd != 8'hEB) begin
            if (CE - 1 < t) q_err.push_back('{CE - 1, 0});
            return;
        end
        a = addr % 256;
        if (CE + 5 < t) q_req.push_back('{CE + 5, a});
        s = CE + 5 + DC;
        for (int e = s; e < t; e++) begin
            i = e - s;
            b = int'(mem[(a + i / 2) % 256]);
            if (i % 2 == 0) begin
                q_nib.push_back('{e, b / 16});
                q_req.push_back('{e, (a + i / 2 + 1) % 256});
            end else begin
                q_nib.push_back('{e, b % 16});
            end
        end
    endtask

    function automatic logic [3:0] lane_val(input logic [7:0] cmd,
                                            input int addr, input int e);
        logic [3:0] r;
        int ai;
        r = 4'($urandom);
`ifdef QSPI_RESP_SPI_CMD_EN
        if (e < CE) r[0] = cmd[7 - e];
`else
        if (e == 0) r = cmd[7:4];
        if (e == 1) r = cmd[3:0];
`endif
        ai = e - CE;
        if (ai >= 0 && ai < 6) r = 4'((addr >> (4 * (5 - ai))) & 15);
        return r;
    endfunction

    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_io_out", int'(io_out), 0);
        chk("rst_io_oe", int'(io_oe), 0);
        chk("rst_mem_req", int'(mem_req), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cmd_err", int'(cmd_err), 0);
        q_req.delete();
        q_nib.delete();
        q_err.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        csb = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; leaves off at the negedge after the csb-high edge.
    task automatic run_txn(input logic [7:0] cmd, input int addr,
                           input int t, input int rst_at);
        push_model(cmd, addr, (rst_at >= 0) ? rst_at : t);
        for (int e = 0; e < t; e++) begin
            if (e == rst_at) begin
                mid_reset();
                return;
            end
            csb   = 1'b0;
            io_in = lane_val(cmd, addr, e);
            @(negedge clk);
        end
        csb   = 1'b1;
        io_in = 4'($urandom);
        @(negedge clk);
        chk("drain", q_req.size() + q_nib.size() + q_err.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [7:0] c;
        rst   = 1'b1;
        csb   = 1'b1;
        io_in = 4'h0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'hA5;
        mem[8'h11] = 8'h3C;
        #2;
        chk("reset_io_out", int'(io_out), 0);
        chk("reset_io_oe", int'(io_oe), 0);
        chk("reset_mem_req", int'(mem_req), 0);
        chk("reset_mem_addr", int'(mem_addr), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_cmd_err", int'(cmd_err), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_txn(8'hEB, 24'h000010, CE + 13, -1);
        run_txn(8'hEB, 24'h0000FF, CE + 15, -1);
        run_txn(8'h9F, 24'h000010, CE + 12, -1);
        run_txn(8'hEB, 24'h000011, CE + 13, -1);
        run_txn(8'hEB, 24'h000020, CE + 3, -1);
        run_txn(8'hEB, 24'h000010, CE + 14, -1);

        for (int n = 0; n < 25; n++) begin
            c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hEB;
            t = $urandom_range(1, 40);
            run_txn(c, int'($urandom_range(0, 24'hFFFFFF)), t, -1);
        end

        run_txn(8'hEB, 24'h000040, CE + 30, CE + 5 + DC + 3);
        run_txn(8'hEB, 24'h0000FE, CE + 16, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
